imem_loader: RTL and testbench

Writer side of the instruction memory: receives a program as a byte stream and writes it word by word into the writable instruction store that the fetch stage reads by word index. It sits between the host byte link (UART receiver or testbench) and the instruction memory write port. It holds the pipeline with `cpu_hold` while a load is in progress.

---
 rtl/imem_loader.sv | 233 +++++++++++++++++++++++
 tb/tb_imem_loader.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Writer side of the instruction memory. Receives a program as a big-endian
// byte stream and writes it word by word into the instruction store. The
// pipeline is held with cpu_hold while a load is in progress.
//
// Stream: LEN_HI, LEN_LO (word count N), N*4 data bytes (MSB first), and,
// when IMEM_LOADER_CHECKSUM_EN is defined, one trailing XOR checksum byte
// covering every byte from LEN_HI through the last data byte.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the CSUM state).
//
// Parameters:
//   DEPTH        number of 32-bit words in instruction memory
//   LEN_W        width of the word-count header register and words_loaded
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        one-cycle pulse that begins a load (ignored while busy)
//   in_byte      stream byte
//   in_valid     in_byte valid
//   in_ready     loader accepts a byte (transfer = in_valid && in_ready)
//   mem_we       one-cycle registered write strobe
//   mem_addr     word index of the write
//   mem_wdata    instruction word to write
//   cpu_hold     stall request to the pipeline (same as busy)
//   busy         load in progress
//   done         last load completed successfully
//   error        last load aborted
//   words_loaded words written in the current or last load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int DEPTH = 400,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_loaded
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_DONE,
    S_ERR,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM
`else
    S_WR_LAST
`endif
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [7:0]       r_len_hi;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_words_loaded;
  logic [1:0]       r_byte_cnt;
  logic [23:0]      r_shift;
  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  logic             w_xfer;
  logic             w_start_load;
  logic [15:0]      w_len_hdr;
  logic             w_hdr_too_big;
  logic             w_hdr_zero;
  logic             w_word_done;
  logic             w_last_word;

  assign w_xfer        = in_valid && in_ready;
  assign w_start_load  = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                   (r_state == S_ERR));
  assign w_len_hdr     = {r_len_hi, in_byte};
  assign w_hdr_too_big = (32'(w_len_hdr) > DEPTH_U);
  assign w_hdr_zero    = (w_len_hdr == 16'd0);
  assign w_word_done   = (r_state == S_DATA) && w_xfer && (r_byte_cnt == 2'd3);
  assign w_last_word   = (r_words_loaded == (r_len - LEN_W'(1)));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) w_state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (w_hdr_too_big) begin
            w_state_next = S_ERR;
          end else if (w_hdr_zero) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_state_next = S_CSUM;
`else
            w_state_next = S_DONE;
`endif
          end else begin
            w_state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && (r_byte_cnt == 2'd3) && w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_state_next = S_CSUM;
`else
          w_state_next = S_WR_LAST;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) w_state_next = (in_byte == r_csum) ? S_DONE : S_ERR;
      end
`else
      // The final write strobe is issued here; done follows one cycle later.
      S_WR_LAST: begin
        busy         = 1'b1;
        w_state_next = S_DONE;
      end
`endif
      S_DONE: begin
        done = 1'b1;
        if (start) w_state_next = S_LEN_HI;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) w_state_next = S_LEN_HI;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: header capture, word assembly, registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len_hi       <= 8'd0;
      r_len          <= '0;
      r_words_loaded <= '0;
      r_byte_cnt     <= 2'd0;
      r_shift        <= 24'd0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= 32'd0;
      r_mem_wdata    <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum         <= 8'd0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      if (w_start_load) begin
        r_words_loaded <= '0;
        r_byte_cnt     <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_csum         <= 8'd0;
`endif
      end
      if (w_xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        // The checksum byte itself is not folded into the running value.
        if (r_state != S_CSUM) r_csum <= r_csum ^ in_byte;
`endif
        if (r_state == S_LEN_HI) r_len_hi <= in_byte;
        if (r_state == S_LEN_LO) r_len <= LEN_W'(w_len_hdr);
        if (r_state == S_DATA) begin
          r_shift    <= {r_shift[15:0], in_byte};
          r_byte_cnt <= r_byte_cnt + 2'd1;
        end
      end
      // Address is the pre-increment count, so word k lands at index k.
      if (w_word_done) begin
        r_mem_we       <= 1'b1;
        r_mem_addr     <= 32'(r_words_loaded);
        r_mem_wdata    <= {r_shift, in_byte};
        r_words_loaded <= r_words_loaded + LEN_W'(1);
      end
    end
  end

  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign words_loaded = r_words_loaded;
  assign cpu_hold     = busy;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. Expected memory writes are pushed to a
// scoreboard queue as each stream is built and popped when mem_we is seen.
// Build with IMEM_LOADER_CHECKSUM_EN defined to exercise the checksum path.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int DEPTH = 400;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0]       in_byte;
  logic             in_valid;
  logic             in_ready;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             cpu_hold;
  logic             busy;
  logic             done;
  logic             error;
  logic [LEN_W-1:0] words_loaded;

  imem_loader #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_byte      (in_byte),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  byte_q[$];
  logic [31:0] prog_q[$];
  logic [31:0] mem_model [0:DEPTH-1];
  int          n_cmp    = 0;
  int          n_bad    = 0;
  int          n_writes = 0;
  bit          gap_en   = 1'b0;

  // Advance one clock, sample #1 later, and retire any write against the
  // scoreboard.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (mem_we === 1'b1) begin
      n_writes++;
      if (int'(mem_addr) < DEPTH) mem_model[int'(mem_addr)] = mem_wdata;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%08h, required no write",
                 mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          n_bad++;
          $display("FAIL write: got addr=%0d data=%08h, required addr=%0d data=%08h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end else begin
          $display("write addr=%0d data=%08h matched", mem_addr, mem_wdata);
        end
      end
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte, optionally after random idle cycles, and return once
  // it has been transferred.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    if (gap_en) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_byte  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got in_ready=%b, required 1 within 50 cycles", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_all();
    while (byte_q.size() > 0) send_byte(byte_q.pop_front());
  endtask

  // Turn prog_q into a byte stream and the matching expected writes.
  task automatic build_stream();
    logic [7:0]  cs;
    logic [15:0] n;
    logic [7:0]  b;
    n  = 16'(prog_q.size());
    cs = 8'h00;
    byte_q.delete();
    byte_q.push_back(n[15:8]);
    byte_q.push_back(n[7:0]);
    cs = n[15:8] ^ n[7:0];
    foreach (prog_q[i]) begin
      exp_q.push_back({32'(i), prog_q[i]});
      for (int k = 3; k >= 0; k--) begin
        b = prog_q[i][8*k +: 8];
        byte_q.push_back(b);
        cs = cs ^ b;
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    byte_q.push_back(cs);
`endif
  endtask

  task automatic wait_end(input string name);
    int guard;
    guard = 0;
    while (done !== 1'b1 && error !== 1'b1 && guard < 10) begin
      tick();
      guard++;
    end
    if (done !== 1'b1 && error !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_end_timeout: got done=%b error=%b, required one of them within 10 cycles",
               name, done, error);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({in_ready, mem_we, cpu_hold, busy, done, error, mem_addr, mem_wdata, words_loaded} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b we=%b hold=%b busy=%b done=%b err=%b addr=%h wdata=%h wl=%0d, required all 0",
               in_ready, mem_we, cpu_hold, busy, done, error, mem_addr, mem_wdata, words_loaded);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({in_ready, busy, done, error} !== 4'b0000) begin
      n_bad++;
      $display("FAIL idle_after_reset: got rdy=%b busy=%b done=%b err=%b, required 0000",
               in_ready, busy, done, error);
    end
    $display("reset checked");
  endtask

  task automatic test_basic();
    prog_q.delete();
    prog_q.push_back(32'h20010005);
    prog_q.push_back(32'hAABBCCDD);
    build_stream();
    do_start();
    n_cmp++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_rise: got busy=%b hold=%b rdy=%b, required 111", busy, cpu_hold, in_ready);
    end
    send_all();
`ifndef IMEM_LOADER_CHECKSUM_EN
    n_cmp++;
    if (mem_we !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL last_write_cycle: got we=%b done=%b busy=%b, required we=1 done=0 busy=1",
               mem_we, done, busy);
    end
    tick();
`endif
    n_cmp++;
    if ({done, error, busy, cpu_hold, in_ready} !== 5'b10000) begin
      n_bad++;
      $display("FAIL basic_done: got done=%b err=%b busy=%b hold=%b rdy=%b, required 10000",
               done, error, busy, cpu_hold, in_ready);
    end
    n_cmp++;
    if (words_loaded !== 16'd2 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL basic_count: got words_loaded=%0d pending=%0d, required 2 and 0",
               words_loaded, exp_q.size());
    end
    $display("basic load checked");
  endtask

  task automatic test_oversize();
    int w0;
    w0 = n_writes;
    byte_q.delete();
    byte_q.push_back(8'h01);
    byte_q.push_back(8'h91);
    do_start();
    send_all();
    n_cmp++;
    if ({error, done, busy, in_ready} !== 4'b1000) begin
      n_bad++;
      $display("FAIL oversize_error: got err=%b done=%b busy=%b rdy=%b, required 1000",
               error, done, busy, in_ready);
    end
    in_byte  = 8'h55;
    in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    n_cmp++;
    if (n_writes != w0 || error !== 1'b1 || words_loaded !== 16'd0) begin
      n_bad++;
      $display("FAIL oversize_no_write: got writes=%0d err=%b wl=%0d, required writes=%0d err=1 wl=0",
               n_writes - w0, error, words_loaded, 0);
    end
    $display("oversize header checked");
  endtask

  task automatic test_zero();
    int w0;
    w0 = n_writes;
    prog_q.delete();
    build_stream();
    do_start();
    send_all();
    n_cmp++;
    if ({done, error, busy} !== 3'b100 || words_loaded !== 16'd0 || n_writes != w0) begin
      n_bad++;
      $display("FAIL zero_load: got done=%b err=%b busy=%b wl=%0d writes=%0d, required 100 wl=0 writes=0",
               done, error, busy, words_loaded, n_writes - w0);
    end
    $display("zero-length load checked");
  endtask

  task automatic test_gaps();
    prog_q.delete();
    for (int i = 0; i < 3; i++) prog_q.push_back($urandom);
    build_stream();
    gap_en = 1'b1;
    do_start();
    repeat (4) send_byte(byte_q.pop_front());
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(byte_q.pop_front());
    start = 1'b1;
    tick();
    start = 1'b0;
    send_all();
    gap_en = 1'b0;
    wait_end("gaps");
    n_cmp++;
    if ({done, error} !== 2'b10 || words_loaded !== 16'd3 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL gaps_result: got done=%b err=%b wl=%0d pending=%0d, required 10 wl=3 pending=0",
               done, error, words_loaded, exp_q.size());
    end
    $display("gapped load checked");
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    prog_q.delete();
    prog_q.push_back(32'h12345678);
    build_stream();
    do_start();
    send_all();
    n_cmp++;
    if ({done, error} !== 2'b10) begin
      n_bad++;
      $display("FAIL csum_good: got done=%b err=%b, required 10", done, error);
    end
    mem_model[0] = 32'h0;
    exp_q.push_back({32'd0, 32'h12345678});
    byte_q.delete();
    byte_q.push_back(8'h00);
    byte_q.push_back(8'h01);
    byte_q.push_back(8'h12);
    byte_q.push_back(8'h34);
    byte_q.push_back(8'h56);
    byte_q.push_back(8'h78);
    byte_q.push_back(8'h00);
    do_start();
    send_all();
    n_cmp++;
    if ({done, error, busy} !== 3'b010 || mem_model[0] !== 32'h12345678) begin
      n_bad++;
      $display("FAIL csum_bad: got done=%b err=%b busy=%b mem0=%08h, required 010 mem0=12345678",
               done, error, busy, mem_model[0]);
    end
    $display("checksum checked");
  endtask
`endif

  task automatic test_rst_mid();
    prog_q.delete();
    prog_q.push_back(32'h11223344);
    prog_q.push_back(32'h55667788);
    build_stream();
    void'(exp_q.pop_back());
    do_start();
    repeat (7) send_byte(byte_q.pop_front());
    byte_q.delete();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({in_ready, mem_we, cpu_hold, busy, done, error, mem_addr, mem_wdata, words_loaded} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got rdy=%b we=%b hold=%b busy=%b done=%b err=%b addr=%h wdata=%h wl=%0d, required all 0",
               in_ready, mem_we, cpu_hold, busy, done, error, mem_addr, mem_wdata, words_loaded);
    end
    rst = 1'b0;
    repeat (3) tick();
    prog_q.delete();
    prog_q.push_back(32'hDEADBEEF);
    build_stream();
    do_start();
    send_all();
    wait_end("rst_mid");
    n_cmp++;
    if ({done, error} !== 2'b10 || words_loaded !== 16'd1 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rst_mid_reload: got done=%b err=%b wl=%0d pending=%0d, required 10 wl=1 pending=0",
               done, error, words_loaded, exp_q.size());
    end
    $display("mid-load reset checked");
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_byte  = 8'h00;
    in_valid = 1'b0;
    test_reset();
    test_basic();
    test_oversize();
    test_zero();
    test_gaps();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_rst_mid();
    repeat (2) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at 500us, required finish");
    $fatal(1, "timeout");
  end

endmodule
